// File: rtl/cva5_types.sv
// Shared type definitions for the instruction-side invalidation path.
// Holds the fence.i drain FSM state encoding used by instruction_invalidation_queue.
package cva5_types;

    // fence.i drain sequencing: wait for the queue to empty, then pulse done.
    typedef enum logic [1:0] {
        FenceIdle  = 2'd0,
        FenceDrain = 2'd1,
        FenceDone  = 2'd2
    } fence_state_t;

endpackage

// File: rtl/inv_addr_fifo.sv
// Circular buffer of invalidation word addresses: pointers, occupancy count and storage.
// When INV_QUEUE_COALESCE_EN is defined, the raw storage and read pointer are exported so the
// parent can compare incoming addresses against queued entries.
module inv_addr_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 30,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_o,
    output logic [CntW-1:0]   count_o,
    output logic              full_o,
`ifdef INV_QUEUE_COALESCE_EN
    output logic [PtrW-1:0]   rd_ptr_o,
    output logic [ADDR_W-1:0] entries_o [DEPTH],
`endif
    output logic              empty_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    // Pointer and count next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; entries are only observed while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);

`ifdef INV_QUEUE_COALESCE_EN
    assign rd_ptr_o  = rd_ptr_q;
    assign entries_o = mem_q;
`endif

endmodule

// File: rtl/instruction_invalidation_queue.sv
// Queues I-cache/line-buffer invalidation requests snooped from stores and offers them to the
// sinks in order, with a fence.i drain handshake.
// Optional feature macro: INV_QUEUE_COALESCE_EN -- drop requests that match a queued non-head entry.
// DEPTH must be a power of two and at least 2.
module instruction_invalidation_queue
    import cva5_types::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              fence_i,
    output logic              fence_i_done,
    output logic              inv_valid,
    output logic [ADDR_W-1:0] inv_addr,
    input  logic              inv_completed,
    output logic              queue_empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fence_state_t      fence_state_q, fence_state_d;
    logic              accept;
    logic              push;
    logic              pop;
    logic              coalesce_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [ADDR_W-1:0] fifo_head;

`ifdef INV_QUEUE_COALESCE_EN
    logic [PtrW-1:0]   fifo_rd_ptr;
    logic [ADDR_W-1:0] fifo_entries [DEPTH];
    logic [PtrW-1:0]   scan_idx;
`endif

    inv_addr_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (req_addr),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
`ifdef INV_QUEUE_COALESCE_EN
        .rd_ptr_o    (fifo_rd_ptr),
        .entries_o   (fifo_entries),
`endif
        .empty_o     (fifo_empty)
    );

    // No full-queue bypass: a pop in the same cycle does not open a slot.
    assign req_ready = ~fifo_full & (fence_state_q == FenceIdle);
    assign accept    = req_valid & req_ready;
    assign pop       = ~fifo_empty & inv_completed;
    assign push      = accept & ~coalesce_hit;

`ifdef INV_QUEUE_COALESCE_EN
    // Match against valid entries behind the head only; the head may already be in flight.
    always_comb begin
        coalesce_hit = 1'b0;
        scan_idx     = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            scan_idx = fifo_rd_ptr + PtrW'(i);
            if ((CntW'(i) < fifo_count) && (fifo_entries[scan_idx] == req_addr)) begin
                coalesce_hit = 1'b1;
            end
        end
    end
`else
    assign coalesce_hit = 1'b0;
`endif

    // Fence FSM next state: drain completes once the last entry leaves the queue.
    always_comb begin
        fence_state_d = fence_state_q;
        unique case (fence_state_q)
            FenceIdle: begin
                if (fence_i) begin
                    fence_state_d = FenceDrain;
                end
            end
            FenceDrain: begin
                if (fifo_empty || ((fifo_count == CntW'(1)) && pop)) begin
                    fence_state_d = FenceDone;
                end
            end
            FenceDone: begin
                fence_state_d = FenceIdle;
            end
            default: begin
                fence_state_d = FenceIdle;
            end
        endcase
    end

    // Fence FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fence_state_q <= FenceIdle;
        end else begin
            fence_state_q <= fence_state_d;
        end
    end

    assign fence_i_done = (fence_state_q == FenceDone);
    assign queue_empty  = fifo_empty;
    assign inv_valid    = ~fifo_empty;
    // Storage is unreset, so force zero while nothing is held.
    assign inv_addr     = fifo_empty ? '0 : fifo_head;

endmodule
